bft_leaf_relay: RTL and testbench

Registered relay stage between a BFT switch port and a leaf page (`page_N`). It breaks the long BFT↔leaf timing path in both directions:
- **Inbound:** a single register with a destination-leaf check.
- **Outbound:** a small FIFO that absorbs the page's packets and generates the page's `resend` (ready) signal from BFT backpressure.

---
 rtl/bft_pkg.sv | 24 ++
 rtl/bft_relay_fifo.sv | 80 ++++++++
 rtl/bft_leaf_relay.sv | 116 +++++++++++
 tb/tb_bft_leaf_relay.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/bft_pkg.sv
// Shared BFT packet layout: field offsets, default packet width and a field extractor.
package bft_pkg;

  localparam int unsigned PACKET_BITS_DEFAULT = 49;

  localparam int unsigned VALID_BIT   = 48;
  localparam int unsigned LEAF_MSB    = 47;
  localparam int unsigned LEAF_LSB    = 43;
  localparam int unsigned PORT_MSB    = 42;
  localparam int unsigned PORT_LSB    = 39;
  localparam int unsigned ADDR_MSB    = 38;
  localparam int unsigned ADDR_LSB    = 32;
  localparam int unsigned PAYLOAD_MSB = 31;

  // Returns bits [msb:lsb] of a packet, right-aligned and zero-extended to 32 bits.
  function automatic logic [31:0] pkt_field(input logic [PACKET_BITS_DEFAULT-1:0] pkt,
                                            input int unsigned msb,
                                            input int unsigned lsb);
    logic [31:0] mask;
    mask = (32'd1 << (msb - lsb + 1)) - 32'd1;
    return 32'(pkt >> lsb) & mask;
  endfunction

endpackage

// File: rtl/bft_relay_fifo.sv
// Synchronous FIFO whose head entry is held in a register so the consumer sees a flop output.
module bft_relay_fifo
  import bft_pkg::*;
#(
  parameter int unsigned WIDTH = PACKET_BITS_DEFAULT,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             pop_c, push_c;

  // A pop while full frees a slot in the same cycle, so the push is still accepted.
  always_comb begin
    pop_c    = 1'b0;
    push_c   = 1'b0;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = '0;
    pop_c    = !empty_q && rd_ready;
    push_c   = wr_valid && (!full_q || pop_c);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
    count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    if (count_d != '0) begin
      // The new head is the entry being written this cycle when the read pointer lands on it.
      if (push_c && (rd_ptr_d == wr_ptr_q)) head_d = wr_data;
      else                                  head_d = mem_q[rd_ptr_d];
    end
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = head_q;
  assign count   = count_q;
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/bft_leaf_relay.sv
// Registered relay between a BFT switch port and a leaf page: filtered inbound register,
// FIFO-buffered outbound path with registered resend. Optional stats via BFT_RELAY_STATS_EN.
module bft_leaf_relay
  import bft_pkg::*;
#(
  parameter int unsigned PACKET_BITS   = PACKET_BITS_DEFAULT,
  parameter int unsigned NUM_LEAF_BITS = 5,
  parameter int unsigned LEAF_ID       = 0,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned AFULL_MARGIN  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PACKET_BITS-1:0] bft_in,
  output logic [PACKET_BITS-1:0] page_din,
  input  logic [PACKET_BITS-1:0] page_dout,
  output logic                   page_resend,
  output logic [PACKET_BITS-1:0] bft_out,
  input  logic                   bft_ready,
  output logic                   overflow
`ifdef BFT_RELAY_STATS_EN
  ,
  output logic [15:0]            drop_count,
  output logic [15:0]            stall_count
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [PACKET_BITS-1:0]   page_din_q, page_din_d;
  logic                     page_resend_q, page_resend_d;
  logic                     overflow_q, overflow_d;
  logic [NUM_LEAF_BITS-1:0] in_leaf_c;
  logic                     in_valid_c, in_match_c;
  logic                     out_valid_c, pop_c, push_c;
  logic [CNT_W-1:0]         count_next_c;
  logic [CNT_W-1:0]         fifo_count;
  logic                     fifo_full, fifo_empty;
  logic [PACKET_BITS-1:0]   fifo_head;

  bft_relay_fifo #(
    .WIDTH (PACKET_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (out_valid_c),
    .wr_data  (page_dout),
    .rd_ready (bft_ready),
    .rd_data  (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Inbound filter, outbound accounting for resend and the sticky overflow flag.
  always_comb begin
    in_leaf_c     = NUM_LEAF_BITS'(pkt_field(PACKET_BITS_DEFAULT'(bft_in), LEAF_MSB, LEAF_LSB));
    in_valid_c    = bft_in[VALID_BIT];
    in_match_c    = in_valid_c && (in_leaf_c == NUM_LEAF_BITS'(LEAF_ID));
    page_din_d    = in_match_c ? bft_in : '0;

    out_valid_c   = page_dout[VALID_BIT];
    pop_c         = !fifo_empty && bft_ready;
    push_c        = out_valid_c && (!fifo_full || pop_c);
    count_next_c  = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
    page_resend_d = (count_next_c < CNT_W'(FIFO_DEPTH - AFULL_MARGIN));
    overflow_d    = overflow_q || (out_valid_c && fifo_full && !pop_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      page_din_q    <= '0;
      page_resend_q <= 1'b1;
      overflow_q    <= 1'b0;
    end else begin
      page_din_q    <= page_din_d;
      page_resend_q <= page_resend_d;
      overflow_q    <= overflow_d;
    end
  end

  assign page_din    = page_din_q;
  assign page_resend = page_resend_q;
  assign bft_out     = fifo_head;
  assign overflow    = overflow_q;

`ifdef BFT_RELAY_STATS_EN
  logic [15:0] drop_count_q, drop_count_d;
  logic [15:0] stall_count_q, stall_count_d;

  // Saturating event counters.
  always_comb begin
    drop_count_d  = drop_count_q;
    stall_count_d = stall_count_q;
    if (in_valid_c && !in_match_c && (drop_count_q != 16'hFFFF))
      drop_count_d = drop_count_q + 16'd1;
    if (fifo_head[VALID_BIT] && !bft_ready && (stall_count_q != 16'hFFFF))
      stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      drop_count_q  <= drop_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign drop_count  = drop_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_bft_leaf_relay.sv
// Scoreboard bench for bft_leaf_relay: stimulus pushes expected packets, a monitor compares.
module tb_bft_leaf_relay;

  localparam int unsigned PB = 49;

  logic          clk = 1'b0;
  logic          reset;
  logic [PB-1:0] bft_in, page_din, page_dout, bft_out;
  logic          page_resend, bft_ready, overflow;
`ifdef BFT_RELAY_STATS_EN
  logic [15:0]   drop_count, stall_count;
`endif

  bft_leaf_relay #(.LEAF_ID(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .bft_in      (bft_in),
    .page_din    (page_din),
    .page_dout   (page_dout),
    .page_resend (page_resend),
    .bft_out     (bft_out),
    .bft_ready   (bft_ready),
    .overflow    (overflow)
`ifdef BFT_RELAY_STATS_EN
    ,
    .drop_count  (drop_count),
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [PB-1:0] exp_in[$];
  logic [PB-1:0] exp_out[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [PB-1:0] mk(input int i);
    logic [PB-1:0] p;
    p = {1'b1, 5'd0, 4'(i), 7'(i), 32'hA000_0000 + 32'(i)};
    return p;
  endfunction

  // Monitor: outputs are stable at the falling edge; a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (page_din[48]) begin
        if (exp_in.size() == 0) check("inbound_unexpected", 64'(page_din), 64'd0);
        else check("inbound_pkt", 64'(page_din), 64'(exp_in.pop_front()));
      end
      if (bft_out[48] && bft_ready) begin
        if (exp_out.size() == 0) check("outbound_unexpected", 64'(bft_out), 64'd0);
        else check("outbound_pkt", 64'(bft_out), 64'(exp_out.pop_front()));
      end
    end
  end

  task automatic wait_drain();
    for (int k = 0; k < 30 && exp_out.size() != 0; k++) cyc();
    check("drain_done", 64'(exp_out.size()), 64'd0);
  endtask

  initial begin
    logic [PB-1:0] p;
    reset = 1'b1; bft_in = '0; page_dout = '0; bft_ready = 1'b0;
    repeat (3) cyc();
    check("rst_page_din", 64'(page_din), 64'd0);
    check("rst_bft_out", 64'(bft_out), 64'd0);
    check("rst_resend", 64'(page_resend), 64'd1);
    check("rst_overflow", 64'(overflow), 64'd0);
    reset = 1'b0;
    cyc();

    // Inbound pass and mismatch
    p = {1'b1, 5'd5, 4'd1, 7'd3, 32'hDEADBEEF};
    bft_in = p; exp_in.push_back(p);
    cyc();
    check("in_pass", 64'(page_din), 64'(p));
    bft_in = {1'b1, 5'd6, 4'd1, 7'd3, 32'hDEADBEEF};
    cyc();
    check("in_mismatch", 64'(page_din), 64'd0);
`ifdef BFT_RELAY_STATS_EN
    check("drop_count", 64'(drop_count), 64'd1);
`endif
    bft_in = {1'b0, 5'd5, 4'd1, 7'd3, 32'h12345678};
    cyc();
    check("in_invalid", 64'(page_din), 64'd0);
    bft_in = '0;
    cyc();

    // Outbound streaming
    bft_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      page_dout = mk(i); exp_out.push_back(mk(i));
      cyc();
      if (i == 0) check("stream_latency", 64'(bft_out), 64'(mk(0)));
      check("stream_resend", 64'(page_resend), 64'd1);
    end
    page_dout = '0;
    wait_drain();
    check("stream_overflow", 64'(overflow), 64'd0);

    // Backpressure fill
    bft_ready = 1'b0;
    page_dout = mk(16); exp_out.push_back(mk(16)); cyc();
    check("bp_resend_cnt1", 64'(page_resend), 64'd1);
    page_dout = mk(17); exp_out.push_back(mk(17)); cyc();
    check("bp_resend_cnt2", 64'(page_resend), 64'd0);
    page_dout = mk(18); exp_out.push_back(mk(18)); cyc();
    page_dout = mk(19); exp_out.push_back(mk(19)); cyc();
    check("bp_full_overflow", 64'(overflow), 64'd0);
    check("bp_hold", 64'(bft_out), 64'(mk(16)));

    // Full with simultaneous pop: push accepted
    bft_ready = 1'b1; page_dout = mk(20); exp_out.push_back(mk(20)); cyc();
    check("full_pushpop_overflow", 64'(overflow), 64'd0);
    check("full_pushpop_resend", 64'(page_resend), 64'd0);

    // Full without pop: packet dropped
    bft_ready = 1'b0; page_dout = mk(21); cyc();
    check("overflow_set", 64'(overflow), 64'd1);
    page_dout = '0; cyc();
    check("overflow_sticky", 64'(overflow), 64'd1);
    bft_ready = 1'b1;
    wait_drain();
    repeat (3) cyc();
    check("drain_resend", 64'(page_resend), 64'd1);

    // Reset with packets queued
    bft_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      page_dout = mk(32 + i); cyc();
    end
    page_dout = '0; reset = 1'b1; cyc();
    check("midrst_bft_out", 64'(bft_out), 64'd0);
    check("midrst_resend", 64'(page_resend), 64'd1);
    check("midrst_overflow", 64'(overflow), 64'd0);
    reset = 1'b0; bft_ready = 1'b1;
    repeat (10) cyc();
    check("midrst_no_emerge", 64'(bft_out), 64'd0);
    check("inbound_leftover", 64'(exp_in.size()), 64'd0);
    check("outbound_leftover", 64'(exp_out.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
